// File: rtl/cpu_seq_pkg.sv
// Shared state encodings and defaults for the multicycle CPU sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BAD    = 3'd6,
    ST_HALT   = 3'd7
  } seq_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/seq_wait_timer.sv
// Counts cycles spent waiting on an external handshake; expired is combinational and
// flags the LIMIT-th consecutive waiting cycle so the caller can bail out that same cycle.
module seq_wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q holds waits already completed, so this cycle is wait number cnt_q+1
  assign expired = en && (cnt_q >= W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with timeout-guarded waits.
// Strobes are decoded from the registered state and live inputs; HALT is sticky until reset.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = TIMEOUT_DEFAULT,
  parameter logic [31:0] RETIRE_RESET_VAL = 32'd0
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cu_halted,
  input  logic        cu_mem_read,
  input  logic        cu_mem_write,
  input  logic        cu_reg_write,
  input  logic        alu_multicycle,
  input  logic        alu_done,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_write,
  output logic        alu_start,
  output logic        rf_write_en,
  output logic        pc_write,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] retire_count
);

  seq_state_e  state_q, state_d;
  logic        fault_q, fault_d;
  logic [31:0] retire_q, retire_d;
  logic        wait_en, wait_clr, wait_expired;
  logic        mem_op;

  assign mem_op = cu_mem_read | cu_mem_write;

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    ir_write    = 1'b0;
    alu_start   = 1'b0;
    rf_write_en = 1'b0;
    pc_write    = 1'b0;
    wait_en     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        wait_en  = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (cu_halted) begin
          state_d = ST_HALT;
        end else if (cu_mem_read && cu_mem_write) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          state_d   = ST_EXEC;
          alu_start = alu_multicycle;
        end
      end
      ST_EXEC: begin
        if (alu_multicycle && !alu_done) begin
          wait_en = 1'b1;
          if (wait_expired) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end
        end else if (mem_op) begin
          state_d = ST_MEM;
        end else if (cu_reg_write) begin
          state_d = ST_WB;
        end else begin
          pc_write = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        wait_en  = 1'b1;
        if (mem_ready) begin
          if (cu_mem_read) begin
            state_d = ST_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (wait_expired) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_WB: begin
        rf_write_en = 1'b1;
        pc_write    = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_HALT: ;
      // the spare code is a corrupted state: park in HALT and report it
      default: begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end
    endcase
  end

  assign wait_clr = (state_d != state_q);
  assign retire_d = retire_q + {31'd0, pc_write};

  seq_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (wait_clr),
    .en     (wait_en),
    .expired(wait_expired)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      fault_q  <= 1'b0;
      retire_q <= RETIRE_RESET_VAL;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      retire_q <= retire_d;
    end
  end

  assign state        = state_q;
  assign halted       = (state_q == ST_HALT) || (state_q == ST_BAD);
  assign fault        = fault_q || (state_q == ST_BAD);
  assign retire_count = retire_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: a reactive memory/ALU driver plus a per-instruction
// reference model of state trace, strobe counts, final state and retire count.
module tb_cpu_sequencer;

  localparam int TO = 16;
  localparam int K_ADDU = 0, K_LW = 1, K_SW = 2, K_MULT = 3, K_JMP = 4, K_HALT = 5, K_ILL = 6;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic cu_halted = 1'b0, cu_mem_read = 1'b0, cu_mem_write = 1'b0, cu_reg_write = 1'b0;
  logic alu_multicycle = 1'b0, alu_done = 1'b0, mem_ready = 1'b0;
  logic imem_req, dmem_req, ir_write, alu_start, rf_write_en, pc_write, halted, fault;
  logic [2:0] state;
  logic [31:0] retire_count;
  logic w_imem_req, w_dmem_req, w_ir_write, w_alu_start, w_rf_write_en, w_pc_write, w_halted, w_fault;
  logic [2:0] w_state;
  logic [31:0] w_retire;

  int total = 0, bad = 0;

  int obs_imem, obs_ir, obs_ast, obs_dmem, obs_rf, obs_pc, obs_len, obs_next;
  logic [191:0] obs_sig;
  logic [31:0] obs_retire;
  logic obs_fault, obs_halted, obs_stuck;

  int exp_imem, exp_ir, exp_ast, exp_dmem, exp_rf, exp_pc, exp_len, exp_next;
  logic [191:0] exp_sig;
  logic [31:0] exp_retire;
  logic exp_fault;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst_b(rst_b), .cu_halted(cu_halted), .cu_mem_read(cu_mem_read),
    .cu_mem_write(cu_mem_write), .cu_reg_write(cu_reg_write), .alu_multicycle(alu_multicycle),
    .alu_done(alu_done), .mem_ready(mem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .ir_write(ir_write), .alu_start(alu_start), .rf_write_en(rf_write_en), .pc_write(pc_write),
    .halted(halted), .fault(fault), .state(state), .retire_count(retire_count)
  );

  cpu_sequencer #(.RETIRE_RESET_VAL(32'hFFFF_FFFE)) dut_wrap (
    .clk(clk), .rst_b(rst_b), .cu_halted(cu_halted), .cu_mem_read(cu_mem_read),
    .cu_mem_write(cu_mem_write), .cu_reg_write(cu_reg_write), .alu_multicycle(alu_multicycle),
    .alu_done(alu_done), .mem_ready(mem_ready), .imem_req(w_imem_req), .dmem_req(w_dmem_req),
    .ir_write(w_ir_write), .alu_start(w_alu_start), .rf_write_en(w_rf_write_en),
    .pc_write(w_pc_write), .halted(w_halted), .fault(w_fault), .state(w_state),
    .retire_count(w_retire)
  );

  task automatic do_reset();
    rst_b = 1'b0;
    {cu_halted, cu_mem_read, cu_mem_write, cu_reg_write} = 4'b0;
    {alu_multicycle, alu_done, mem_ready} = 3'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    exp_retire = 32'd0;
  endtask

  task automatic set_ctrl(input int kind);
    cu_halted      = (kind == K_HALT);
    cu_mem_read    = (kind == K_LW) || (kind == K_ILL);
    cu_mem_write   = (kind == K_SW) || (kind == K_ILL);
    cu_reg_write   = (kind == K_ADDU) || (kind == K_LW) || (kind == K_MULT) ||
                     ((kind == K_ILL) && 1'($urandom));
    alu_multicycle = (kind == K_MULT);
  endtask

  // Fetch data after f extra cycles, ALU result on the a-th EXEC cycle, data after m extra cycles.
  task automatic run_instr(input int kind, input int f, input int a, input int m);
    int fc = 0, ec = 0, mc = 0;
    bit done = 0;
    set_ctrl(kind);
    {obs_imem, obs_ir, obs_ast, obs_dmem, obs_rf, obs_pc, obs_len} = '0;
    obs_sig = '0;
    for (int n = 0; n < 120 && !done; n++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      alu_done  = 1'($urandom);
      if (state == 3'd1) begin
        mem_ready = (fc == f);
        fc++;
      end else if (state == 3'd3 && alu_multicycle) begin
        alu_done = (ec == a - 1);
        ec++;
      end else if (state == 3'd4) begin
        mem_ready = (mc == m);
        mc++;
      end
      #1;
      obs_sig = {obs_sig[188:0], state};
      obs_len++;
      obs_imem += imem_req ? 1 : 0;
      obs_ir   += ir_write ? 1 : 0;
      obs_ast  += alu_start ? 1 : 0;
      obs_dmem += dmem_req ? 1 : 0;
      obs_rf   += rf_write_en ? 1 : 0;
      obs_pc   += pc_write ? 1 : 0;
      if (pc_write || halted) done = 1;
    end
    obs_stuck = !done;
    @(posedge clk);
    #1;
    obs_next   = int'(state);
    obs_retire = retire_count;
    obs_fault  = fault;
    obs_halted = halted;
  endtask

  function automatic void exp_push(input int st, input int times);
    for (int i = 0; i < times; i++) begin
      exp_sig = {exp_sig[188:0], 3'(st)};
      exp_len++;
    end
  endfunction

  // Expected behaviour of one instruction from the sequencing rules, in cycle counts.
  task automatic model_instr(input int kind, input int f, input int a, input int m);
    bit is_mem = (kind == K_LW) || (kind == K_SW);
    bit is_wb  = (kind == K_LW) || (kind == K_ADDU) || (kind == K_MULT);
    {exp_imem, exp_ir, exp_ast, exp_dmem, exp_rf, exp_pc, exp_len} = '0;
    exp_sig = '0;
    exp_fault = 1'b1;
    exp_next = 7;
    if (f >= TO) begin
      exp_imem = TO;
      exp_push(1, TO);
      exp_push(7, 1);
      return;
    end
    exp_imem = f + 1;
    exp_ir = 1;
    exp_push(1, f + 1);
    exp_push(2, 1);
    if (kind == K_HALT || kind == K_ILL) begin
      exp_fault = (kind == K_ILL);
      exp_push(7, 1);
      return;
    end
    exp_ast = (kind == K_MULT) ? 1 : 0;
    if (kind == K_MULT && a > TO) begin
      exp_push(3, TO);
      exp_push(7, 1);
      return;
    end
    exp_push(3, (kind == K_MULT) ? a : 1);
    if (is_mem) begin
      if (m >= TO) begin
        exp_dmem = TO;
        exp_push(4, TO);
        exp_push(7, 1);
        return;
      end
      exp_dmem = m + 1;
      exp_push(4, m + 1);
    end
    if (is_wb) begin
      exp_rf = 1;
      exp_push(5, 1);
    end
    exp_pc = 1;
    exp_fault = 1'b0;
    exp_next = 1;
    exp_retire = exp_retire + 32'd1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {cu_halted, cu_mem_read, cu_mem_write, cu_reg_write} = 4'($urandom);
      {alu_multicycle, alu_done, mem_ready} = 3'($urandom);
    end
    #1;
    total++;
    if ({state, retire_count, fault, halted, imem_req, dmem_req, ir_write, alu_start,
         rf_write_en, pc_write} !== '0) begin
      bad++;
      $display("FAIL reset_state: state=%0d retire=%0d fault=%b halted=%b strobes=%b, want all zero",
               state, retire_count, fault, halted,
               {imem_req, dmem_req, ir_write, alu_start, rf_write_en, pc_write});
    end
    @(negedge clk);
    {cu_halted, cu_mem_read, cu_mem_write, cu_reg_write, alu_multicycle, alu_done, mem_ready} = '0;
    rst_b = 1'b1;
    #1;
    total++;
    if (state !== 3'd0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: state=%0d imem_req=%b, want 0/0", state, imem_req);
    end
    @(negedge clk);
    #1;
    total++;
    if (state !== 3'd1 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL idle_to_fetch: state=%0d imem_req=%b, want 1/1", state, imem_req);
    end
  endtask

  task automatic test_directed();
    int dk[7] = '{K_ADDU, K_LW, K_MULT, K_SW, K_JMP, K_MULT, K_LW};
    int df[7] = '{0, 3, 1, 2, 0, 0, 0};
    int da[7] = '{1, 1, 5, 1, 1, 40, 1};
    int dm[7] = '{0, 3, 0, 0, 0, 0, 20};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      run_instr(dk[i], df[i], da[i], dm[i]);
      model_instr(dk[i], df[i], da[i], dm[i]);
      total++;
      if (obs_len !== exp_len || obs_sig !== exp_sig) begin
        bad++;
        $display("FAIL dir_trace[%0d]: got len=%0d sig=%h want len=%0d sig=%h",
                 i, obs_len, obs_sig, exp_len, exp_sig);
      end
      total++;
      if ({8'(obs_imem), 8'(obs_ir), 8'(obs_ast), 8'(obs_dmem), 8'(obs_rf), 8'(obs_pc)} !==
          {8'(exp_imem), 8'(exp_ir), 8'(exp_ast), 8'(exp_dmem), 8'(exp_rf), 8'(exp_pc)}) begin
        bad++;
        $display("FAIL dir_counts[%0d]: got %0d %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d %0d",
                 i, obs_imem, obs_ir, obs_ast, obs_dmem, obs_rf, obs_pc,
                 exp_imem, exp_ir, exp_ast, exp_dmem, exp_rf, exp_pc);
      end
      total++;
      if (obs_next !== exp_next || obs_fault !== exp_fault || obs_halted !== (exp_next == 7) ||
          obs_retire !== exp_retire || obs_stuck !== 1'b0) begin
        bad++;
        $display("FAIL dir_end[%0d]: got st=%0d fault=%b halted=%b retire=%0d stuck=%b want %0d %b %b %0d 0",
                 i, obs_next, obs_fault, obs_halted, obs_retire, obs_stuck,
                 exp_next, exp_fault, exp_next == 7, exp_retire);
      end
    end
  endtask

  task automatic test_back_to_back();
    int kind, f, a, m;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      kind = $urandom_range(0, 4);
      f = $urandom_range(0, 6);
      a = $urandom_range(1, 8);
      m = $urandom_range(0, 6);
      run_instr(kind, f, a, m);
      model_instr(kind, f, a, m);
      total++;
      if (obs_len !== exp_len || obs_sig !== exp_sig) begin
        bad++;
        $display("FAIL b2b_trace[%0d] k=%0d: got len=%0d sig=%h want len=%0d sig=%h",
                 i, kind, obs_len, obs_sig, exp_len, exp_sig);
      end
      total++;
      if ({8'(obs_imem), 8'(obs_ir), 8'(obs_ast), 8'(obs_dmem), 8'(obs_rf), 8'(obs_pc)} !==
          {8'(exp_imem), 8'(exp_ir), 8'(exp_ast), 8'(exp_dmem), 8'(exp_rf), 8'(exp_pc)}) begin
        bad++;
        $display("FAIL b2b_counts[%0d]: got %0d %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d %0d",
                 i, obs_imem, obs_ir, obs_ast, obs_dmem, obs_rf, obs_pc,
                 exp_imem, exp_ir, exp_ast, exp_dmem, exp_rf, exp_pc);
      end
      total++;
      if (obs_next !== 1 || obs_fault !== 1'b0 || obs_retire !== exp_retire || obs_stuck !== 1'b0) begin
        bad++;
        $display("FAIL b2b_end[%0d]: got st=%0d fault=%b retire=%0d stuck=%b want 1 0 %0d 0",
                 i, obs_next, obs_fault, obs_retire, obs_stuck, exp_retire);
      end
    end
  endtask

  task automatic test_fetch_timeout();
    int viol = 0;
    do_reset();
    run_instr(K_ADDU, 99, 1, 0);
    total++;
    if (obs_imem !== TO || obs_pc !== 0 || obs_next !== 7 || obs_fault !== 1'b1 ||
        obs_halted !== 1'b1) begin
      bad++;
      $display("FAIL fetch_timeout: imem=%0d pc=%0d st=%0d fault=%b halted=%b want %0d 0 7 1 1",
               obs_imem, obs_pc, obs_next, obs_fault, obs_halted, TO);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      {cu_halted, cu_mem_read, cu_mem_write, cu_reg_write} = 4'($urandom);
      {alu_multicycle, alu_done, mem_ready} = 3'($urandom);
      #1;
      if (state !== 3'd7 || halted !== 1'b1 || fault !== 1'b1 ||
          {imem_req, dmem_req, ir_write, alu_start, rf_write_en, pc_write} !== 6'b0)
        viol++;
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL halt_sticky: %0d cycles left HALT or strobed, want 0", viol);
    end
  endtask

  task automatic test_decode_halt();
    int kinds[2] = '{K_HALT, K_ILL};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      run_instr(kinds[i], i + 1, 1, 0);
      model_instr(kinds[i], i + 1, 1, 0);
      total++;
      if (obs_sig !== exp_sig || obs_len !== exp_len || obs_pc !== 0) begin
        bad++;
        $display("FAIL decode_halt_trace[%0d]: got len=%0d sig=%h pc=%0d want len=%0d sig=%h pc=0",
                 i, obs_len, obs_sig, obs_pc, exp_len, exp_sig);
      end
      total++;
      if (obs_next !== 7 || obs_halted !== 1'b1 || obs_fault !== exp_fault) begin
        bad++;
        $display("FAIL decode_halt_end[%0d]: got st=%0d halted=%b fault=%b want 7 1 %b",
                 i, obs_next, obs_halted, obs_fault, exp_fault);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    bit reached = 0;
    do_reset();
    run_instr(K_ADDU, 0, 1, 0);
    total++;
    if (obs_retire !== 32'd1) begin
      bad++;
      $display("FAIL pre_reset_retire: got %0d want 1", obs_retire);
    end
    set_ctrl(K_LW);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (state == 3'd4) begin
        reached = 1;
        break;
      end
      mem_ready = (state == 3'd1);
      alu_done = 1'b0;
    end
    mem_ready = 1'b0;
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL reach_mem: state=%0d never reached 4 within 20 cycles", state);
    end
    #2 rst_b = 1'b0;
    #1;
    total++;
    if (state !== 3'd0 || retire_count !== 32'd0 || dmem_req !== 1'b0 || fault !== 1'b0 ||
        halted !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: st=%0d retire=%0d dmem=%b fault=%b halted=%b want 0 0 0 0 0",
               state, retire_count, dmem_req, fault, halted);
    end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_wrap();
    do_reset();
    total++;
    if (w_retire !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL wrap_preset: got %h want fffffffe", w_retire);
    end
    run_instr(K_ADDU, 0, 1, 0);
    total++;
    if (w_retire !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_first: got %h want ffffffff", w_retire);
    end
    run_instr(K_JMP, 1, 1, 0);
    total++;
    if (w_retire !== 32'd0 || retire_count !== 32'd2) begin
      bad++;
      $display("FAIL wrap_zero: got wrap=%h main=%0d want 00000000 2", w_retire, retire_count);
    end
  endtask

  initial begin
    exp_retire = 32'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_fetch_timeout();
    test_decode_halt();
    test_reset_mid_mem();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
